// File: rtl/ltcminer_pkg.sv
// Shared constants, types and helpers for the miner's host-facing blocks.
package ltcminer_pkg;

    localparam int unsigned NONCE_W         = 32;
    localparam int unsigned BYTES_PER_NONCE = 4;
    localparam int unsigned UART_FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // hash_clk cycles per UART bit, truncated.
    function automatic int unsigned uart_div(input int unsigned speed_mhz,
                                             input int unsigned baud);
        return (speed_mhz * 32'd1000000) / baud;
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Small circular queue of golden nonces; a push while full is honoured only when a pop
// frees a slot in the same cycle.
module nonce_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("nonce_fifo: DEPTH must be a power of 2, minimum 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FullCount);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/nonce_uart_tx.sv
// Queues golden nonces and sends each to the host as four 8N1 bytes, LSB byte first.
module nonce_uart_tx
    import ltcminer_pkg::*;
#(
    parameter int unsigned SPEED_MHZ  = 25,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               hash_clk,
    input  logic               rst_n,
    input  logic [NONCE_W-1:0] golden_nonce,
    input  logic               golden_nonce_match,
    output logic               txd,
    output logic               busy,
    output logic               fifo_full,
    output logic [7:0]         dropped
);

    localparam int unsigned DIV = uart_div(SPEED_MHZ, BAUD);
    localparam int unsigned CW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BitReload = CW'(DIV - 1);
    localparam logic [1:0]    LastByte  = 2'(BYTES_PER_NONCE - 1);
    localparam logic [2:0]    LastBit   = 3'(UART_FRAME_BITS - 3);

    if (DIV < 2) begin : g_div_check
        $error("nonce_uart_tx: SPEED_MHZ*1e6/BAUD must be at least 2");
    end

    tx_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [1:0]         byte_idx_q, byte_idx_d;
    logic [NONCE_W-1:0] shreg_q, shreg_d;
    logic               txd_q, txd_d;
    logic               busy_q, busy_d;
    logic [7:0]         dropped_q, dropped_d;

    logic               pop;
    logic               fifo_empty;
    logic               fifo_full_w;
    logic [NONCE_W-1:0] fifo_data;
    logic [7:0]         cur_byte;
    logic [2:0]         bit_nxt;

    nonce_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (NONCE_W)
    ) u_fifo (
        .clk       (hash_clk),
        .rst_n     (rst_n),
        .push      (golden_nonce_match),
        .push_data (golden_nonce),
        .pop       (pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full_w)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        txd_d      = txd_q;
        dropped_d  = dropped_q;
        pop        = 1'b0;
        cur_byte   = shreg_q[7:0];
        bit_nxt    = bit_idx_q + 3'd1;

        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_d    = fifo_data;
                    byte_idx_d = '0;
                    cnt_d      = BitReload;
                    txd_d      = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d     = BitReload;
                    bit_idx_d = '0;
                    txd_d     = cur_byte[0];
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BitReload;
                    if (bit_idx_q == LastBit) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_nxt;
                        txd_d     = cur_byte[bit_nxt];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (byte_idx_q != LastByte) begin
                        // Next byte starts with no idle gap after this stop bit.
                        shreg_d    = shreg_q >> 8;
                        byte_idx_d = byte_idx_q + 2'd1;
                        cnt_d      = BitReload;
                        txd_d      = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (golden_nonce_match && fifo_full_w && !pop && dropped_q != 8'hff) begin
            dropped_d = dropped_q + 8'd1;
        end
        busy_d = (state_q != IDLE) || !fifo_empty;
    end

    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shreg_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            dropped_q  <= dropped_d;
        end
    end

    assign txd       = txd_q;
    assign busy      = busy_q;
    assign fifo_full = fifo_full_w;
    assign dropped   = dropped_q;

endmodule

// File: tb/tb_nonce_uart_tx.sv
// Bench for nonce_uart_tx: an edge-by-edge queue model predicts acceptance, drops and pop
// times; a mid-bit UART receiver decodes txd for comparison.
module tb_nonce_uart_tx;

    localparam int unsigned SPEED     = 1;
    localparam int unsigned BAUD_T    = 250000;
    localparam int          DEPTH     = 4;
    localparam int          DIV       = (SPEED * 1000000) / BAUD_T;
    localparam int          NONCE_CYC = 40 * DIV + 1;

    logic        hash_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] golden_nonce = '0;
    logic        golden_nonce_match = 1'b0;
    logic        txd, busy, fifo_full;
    logic [7:0]  dropped;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int rst_epoch = 0;
    int frame_err = 0;
    logic [7:0] rx_b[$];
    int         rx_t[$];

    nonce_uart_tx #(
        .SPEED_MHZ  (SPEED),
        .BAUD       (BAUD_T),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .hash_clk           (hash_clk),
        .rst_n              (rst_n),
        .golden_nonce       (golden_nonce),
        .golden_nonce_match (golden_nonce_match),
        .txd                (txd),
        .busy               (busy),
        .fifo_full          (fifo_full),
        .dropped            (dropped)
    );

    always #5 hash_clk = ~hash_clk;
    always @(posedge hash_clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_epoch <= rst_epoch + 1;

    // Mid-bit receiver; a frame interrupted by reset is discarded.
    always begin : rx_mon
        int n0, ep;
        logic [9:0] fr;
        @(negedge hash_clk);
        if (rst_n === 1'b1 && txd === 1'b0) begin
            n0 = cyc;
            ep = rst_epoch;
            for (int k = 0; k < 10; k++) begin
                repeat ((k == 0) ? (DIV / 2 - 1) : DIV) @(negedge hash_clk);
                fr[k] = txd;
            end
            if (ep == rst_epoch && rst_n === 1'b1) begin
                rx_b.push_back(fr[8:1]);
                rx_t.push_back(n0);
                if (fr[0] !== 1'b0 || fr[9] !== 1'b1) frame_err++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_dropped", 32'(dropped), 32'd0);
        repeat (2) @(negedge hash_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge hash_clk);
    endtask

    // Drives pulses at edge offsets offs[] (sorted) and checks against the queue model.
    task automatic run_scn(input string tag, input int offs[$], input logic [31:0] vals[$]);
        logic [31:0] mq[$];
        logic [31:0] exp_n[$];
        logic [31:0] w;
        int pop_t[$];
        int drops, idle_from, act_until, pi, base, last_t, fe0, need, waited, budget, occ_b;
        bit prev_act, prev_ne, p, pop, acc;
        drops = 0; idle_from = 0; act_until = -1; pi = 0;
        prev_act = 1'b0; prev_ne = 1'b0;
        rx_b.delete();
        rx_t.delete();
        fe0 = frame_err;
        last_t = offs[offs.size() - 1] + 3;
        @(negedge hash_clk);
        base = cyc + 1;
        for (int t = 0; t <= last_t; t++) begin
            p = (pi < offs.size()) && (offs[pi] == t);
            golden_nonce_match = p;
            golden_nonce = p ? vals[pi] : $urandom();
            occ_b = mq.size();
            pop = (occ_b > 0) && (t >= idle_from);
            acc = p && ((occ_b < DEPTH) || pop);
            if (pop) begin
                exp_n.push_back(mq.pop_front());
                pop_t.push_back(t);
                idle_from = t + NONCE_CYC;
                act_until = t + 40 * DIV - 1;
            end
            if (acc) mq.push_back(vals[pi]);
            else if (p && drops < 255) drops++;
            if (p) pi++;
            @(negedge hash_clk);
            chk({tag, ":busy"}, 32'(busy), 32'(prev_act || prev_ne));
            chk({tag, ":fifo_full"}, 32'(fifo_full), 32'(mq.size() == DEPTH));
            chk({tag, ":dropped"}, 32'(dropped), 32'(drops));
            prev_act = (t <= act_until);
            prev_ne = (mq.size() > 0);
        end
        golden_nonce_match = 1'b0;
        while (mq.size() > 0) begin
            exp_n.push_back(mq.pop_front());
            pop_t.push_back(idle_from);
            idle_from += NONCE_CYC;
        end
        need = 4 * exp_n.size();
        budget = (exp_n.size() + 2) * NONCE_CYC;
        waited = 0;
        while (rx_b.size() < need && waited < budget) begin
            @(negedge hash_clk);
            waited++;
        end
        chk({tag, ":byte_count"}, 32'(rx_b.size()), 32'(need));
        for (int i = 0; i < need && i < rx_b.size(); i++) begin
            w = exp_n[i / 4];
            chk({tag, ":byte"}, 32'(rx_b[i]), 32'(8'(w >> (8 * (i % 4)))));
            chk({tag, ":byte_start"}, 32'(rx_t[i] - base), 32'(pop_t[i / 4] + 10 * DIV * (i % 4)));
        end
        repeat (2 * NONCE_CYC) @(negedge hash_clk);
        chk({tag, ":no_extra"}, 32'(rx_b.size()), 32'(need));
        chk({tag, ":framing"}, 32'(frame_err), 32'(fe0));
        chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ":idle_txd"}, 32'(txd), 32'd1);
        chk({tag, ":final_dropped"}, 32'(dropped), 32'(drops));
    endtask

    initial begin
        int o[$];
        logic [31:0] v[$];
        int t, base;
        logic [31:0] nz;

        #2 rst_n = 1'b0;
        #1;
        chk("reset:txd", 32'(txd), 32'd1);
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:fifo_full", 32'(fifo_full), 32'd0);
        chk("reset:dropped", 32'(dropped), 32'd0);
        repeat (3) @(negedge hash_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge hash_clk);

        o.delete(); v.delete();
        o.push_back(0); v.push_back(32'h0000318f);
        run_scn("single", o, v);

        do_reset();
        o.delete(); v.delete();
        o.push_back(0); v.push_back(32'h11223344);
        o.push_back(1); v.push_back(32'hAABBCCDD);
        run_scn("b2b", o, v);

        do_reset();
        o.delete(); v.delete();
        for (int i = 0; i < 7; i++) begin
            o.push_back(i);
            v.push_back($urandom());
        end
        run_scn("overflow", o, v);

        do_reset();
        o.delete(); v.delete();
        for (int i = 0; i < 5; i++) begin
            o.push_back(i);
            v.push_back($urandom());
        end
        o.push_back(1 + NONCE_CYC); v.push_back($urandom());
        o.push_back(2 + NONCE_CYC); v.push_back($urandom());
        run_scn("pushpop_full", o, v);

        do_reset();
        o.delete(); v.delete();
        for (int i = 0; i < 305; i++) begin
            o.push_back(i);
            v.push_back($urandom());
        end
        run_scn("saturate", o, v);
        chk("saturate:dropped_max", 32'(dropped), 32'd255);

        do_reset();
        o.delete(); v.delete();
        t = $urandom_range(0, 5);
        for (int i = 0; i < 12; i++) begin
            o.push_back(t);
            v.push_back($urandom());
            t += $urandom_range(1, 250);
        end
        run_scn("random", o, v);

        // Reset during data bit 3 of byte 1 of the first nonce, with drops pending.
        do_reset();
        nz = $urandom() & 32'hFFFF_F7FF;
        @(negedge hash_clk);
        golden_nonce_match = 1'b1;
        golden_nonce = nz;
        base = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge hash_clk);
            golden_nonce = $urandom();
        end
        @(negedge hash_clk);
        golden_nonce_match = 1'b0;
        while (cyc < base + 58) @(negedge hash_clk);
        chk("midrst:pre_txd", 32'(txd), 32'd0);
        chk("midrst:pre_dropped", 32'(dropped), 32'd2);
        chk("midrst:pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst:txd", 32'(txd), 32'd1);
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:dropped", 32'(dropped), 32'd0);
        chk("midrst:fifo_full", 32'(fifo_full), 32'd0);
        repeat (3) @(negedge hash_clk);
        rst_n = 1'b1;
        rx_b.delete();
        rx_t.delete();
        repeat (2 * NONCE_CYC) @(negedge hash_clk);
        chk("midrst:no_residual", 32'(rx_b.size()), 32'd0);
        chk("midrst:idle_txd", 32'(txd), 32'd1);
        chk("midrst:idle_busy", 32'(busy), 32'd0);

        o.delete(); v.delete();
        o.push_back(0); v.push_back(32'h00000001);
        run_scn("post_rst", o, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
